// File: rtl/draw_scheduler.sv
// Frame draw sequencer: swaps VRAM buffers on each frame event, tiles the background
// sprite across the back buffer, then blits the enabled sprite-table slots in order.
module draw_scheduler #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int SPRITE_SIZE   = 32,
  parameter int SPRITE_SLOTS  = 4,
  parameter int BG_INDEX      = 7,
  parameter int TRANSPARENT   = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_screenend,
  output logic [1:0]  o_cmd_idx,
  input  logic        i_cmd_en,
  input  logic [9:0]  i_cmd_x,
  input  logic [8:0]  i_cmd_y,
  input  logic [2:0]  i_cmd_spr,
  output logic [12:0] o_spr_addr,
  input  logic [7:0]  i_spr_data,
  output logic [15:0] o_fb_addr,
  output logic [7:0]  o_fb_data,
  output logic        o_fb_we,
  output logic        o_back_buf,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int SH = $clog2(SPRITE_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_BG, S_FETCH, S_DRAW, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        back_q, back_d;
  logic        ovr_q, ovr_d;
  logic [1:0]  slot_q, slot_d;
  logic [9:0]  cx_q, cx_d;
  logic [8:0]  cy_q, cy_d;
  logic [9:0]  sx_q, sx_d;
  logic [8:0]  sy_q, sy_d;
  logic [2:0]  spr_q, spr_d;
  logic        vld_q, vld_d;
  logic        keep_q, keep_d;
  logic        chk_q, chk_d;
  logic [15:0] addr_q, addr_d;

  logic        frame_evt;
  logic        busy;
  logic        last_slot;
  logic [10:0] tx;
  logic [9:0]  ty;

  assign frame_evt = i_pix_stb & i_screenend;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign last_slot = (slot_q == 2'(SPRITE_SLOTS - 1));
  // In DRAW the shared x/y counters hold px/py; sums are wide enough never to wrap.
  assign tx        = 11'(sx_q) + 11'(cx_q);
  assign ty        = 10'(sy_q) + 10'(cy_q);

  always_comb begin
    state_d    = state_q;
    back_d     = back_q;
    ovr_d      = frame_evt & busy;
    slot_d     = slot_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    spr_d      = spr_q;
    vld_d      = 1'b0;
    keep_d     = 1'b0;
    chk_d      = 1'b0;
    addr_d     = addr_q;
    o_spr_addr = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (frame_evt) begin
          back_d  = ~back_q;
          cx_d    = '0;
          cy_d    = '0;
          slot_d  = '0;
          state_d = S_BG;
        end
      end
      S_BG: begin
        o_spr_addr = 13'(BG_INDEX * SPRITE_SIZE * SPRITE_SIZE
                         + SPRITE_SIZE * 32'(cy_q[SH-1:0]) + 32'(cx_q[SH-1:0]));
        vld_d  = 1'b1;
        keep_d = 1'b1;
        addr_d = 16'(32'(cy_q) * SCREEN_WIDTH + 32'(cx_q));
        if (cx_q == 10'(SCREEN_WIDTH - 1)) begin
          cx_d = '0;
          if (cy_q == 9'(SCREEN_HEIGHT - 1)) begin
            cy_d    = '0;
            slot_d  = '0;
            state_d = S_FETCH;
          end else begin
            cy_d = cy_q + 9'd1;
          end
        end else begin
          cx_d = cx_q + 10'd1;
        end
      end
      S_FETCH: begin
        sx_d  = i_cmd_x;
        sy_d  = i_cmd_y;
        spr_d = i_cmd_spr;
        if (i_cmd_en) begin
          cx_d    = '0;
          cy_d    = '0;
          state_d = S_DRAW;
        end else if (last_slot) begin
          state_d = S_DRAIN;
        end else begin
          slot_d = slot_q + 2'd1;
        end
      end
      S_DRAW: begin
        o_spr_addr = 13'(32'(spr_q) * SPRITE_SIZE * SPRITE_SIZE
                         + SPRITE_SIZE * 32'(cy_q) + 32'(cx_q));
        vld_d  = 1'b1;
        chk_d  = 1'b1;
        keep_d = (tx < 11'(SCREEN_WIDTH)) && (ty < 10'(SCREEN_HEIGHT));
        addr_d = 16'(32'(ty) * SCREEN_WIDTH + 32'(tx));
        if (cx_q == 10'(SPRITE_SIZE - 1)) begin
          cx_d = '0;
          if (cy_q == 9'(SPRITE_SIZE - 1)) begin
            cy_d = '0;
            if (last_slot) begin
              state_d = S_DRAIN;
            end else begin
              slot_d  = slot_q + 2'd1;
              state_d = S_FETCH;
            end
          end else begin
            cy_d = cy_q + 9'd1;
          end
        end else begin
          cx_d = cx_q + 10'd1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      back_q  <= 1'b0;
      ovr_q   <= 1'b0;
      slot_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      vld_q   <= 1'b0;
      keep_q  <= 1'b0;
      chk_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      back_q  <= back_d;
      ovr_q   <= ovr_d;
      slot_q  <= slot_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      vld_q   <= vld_d;
      keep_q  <= keep_d;
      chk_q   <= chk_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    sx_q  <= sx_d;
    sy_q  <= sy_d;
    spr_q <= spr_d;
  end

  // Write stage: sprite data arrives this cycle, so the transparency test is applied here.
  assign o_fb_we    = vld_q & keep_q & ~(chk_q & (i_spr_data == 8'(TRANSPARENT)));
  assign o_fb_data  = o_fb_we ? i_spr_data : 8'd0;
  assign o_fb_addr  = addr_q;
  assign o_cmd_idx  = slot_q;
  assign o_back_buf = back_q;
  assign o_busy     = busy;
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected VRAM writes are queued by the stimulus
// and popped by a monitor on every o_fb_we; control outputs are checked directly.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_stb, screenend;
  logic [1:0]  cmd_idx;
  logic        cmd_en;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [2:0]  cmd_spr;
  logic [12:0] spr_addr;
  logic [7:0]  spr_data = 8'd0;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we, back_buf, busy, overrun;

  logic        tab_en  [4];
  logic [9:0]  tab_x   [4];
  logic [8:0]  tab_y   [4];
  logic [2:0]  tab_spr [4];

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int max_addr = 0;
  int cnt;
  int bound_hit;

  always #5 clk = ~clk;

  draw_scheduler dut (
    .i_clk(clk), .i_rst(rst_n), .i_pix_stb(pix_stb), .i_screenend(screenend),
    .o_cmd_idx(cmd_idx), .i_cmd_en(cmd_en), .i_cmd_x(cmd_x), .i_cmd_y(cmd_y),
    .i_cmd_spr(cmd_spr), .o_spr_addr(spr_addr), .i_spr_data(spr_data),
    .o_fb_addr(fb_addr), .o_fb_data(fb_data), .o_fb_we(fb_we),
    .o_back_buf(back_buf), .o_busy(busy), .o_overrun(overrun)
  );

  assign cmd_en  = tab_en[cmd_idx];
  assign cmd_x   = tab_x[cmd_idx];
  assign cmd_y   = tab_y[cmd_idx];
  assign cmd_spr = tab_spr[cmd_idx];

  // Sprite buffer contents: sprites 3 and 7 are transparent (0) on even columns.
  function automatic logic [7:0] spr_mem(input int a);
    int s;
    s = a >> 10;
    if ((s == 3 || s == 7) && (a % 2 == 0)) return 8'd0;
    return 8'(a % 251 + 1);
  endfunction

  always @(posedge clk) spr_data <= spr_mem(int'(spr_addr));

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_bg(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      int x, y;
      x = i % 320;
      y = i / 320;
      w.addr = y * 320 + x;
      w.data = int'(spr_mem(7 * 1024 + (y % 32) * 32 + (x % 32)));
      exp_q.push_back(w);
    end
  endtask

  task automatic push_sprite(input int sx, input int sy, input int s);
    for (int py = 0; py < 32; py++)
      for (int px = 0; px < 32; px++) begin
        wr_t w;
        int d;
        d = int'(spr_mem(s * 1024 + py * 32 + px));
        if (sx + px < 320 && sy + py < 180 && d != 0) begin
          w.addr = (sy + py) * 320 + sx + px;
          w.data = d;
          exp_q.push_back(w);
        end
      end
  endtask

  task automatic frame_event();
    @(negedge clk);
    pix_stb = 1'b1;
    screenend = 1'b1;
    @(negedge clk);
    pix_stb = 1'b0;
    screenend = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int limit);
    bound_hit = 1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        bound_hit = 0;
        break;
      end
    end
    check(name, bound_hit, 0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (fb_we) begin
      nwr++;
      if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fb_write got addr %0d data %0d want no write", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(fb_addr) != e.addr || int'(fb_data) != e.data) begin
          errors++;
          $display("FAIL fb_write got addr %0d data %0d want addr %0d data %0d",
                   fb_addr, fb_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pix_stb = 1'b0;
    screenend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tab_en[i] = 1'b0;
      tab_x[i] = '0;
      tab_y[i] = '0;
      tab_spr[i] = 3'(i);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_back_buf", int'(back_buf), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_cmd_idx", int'(cmd_idx), 0);
    check("rst_spr_addr", int'(spr_addr), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Partial frame, then reset in the middle of the background fill.
    push_bg(5000);
    frame_event();
    check("swap_first", int'(back_buf), 1);
    check("busy_bg", int'(busy), 1);
    wait_drained("bg5000_timeout", 6000);
    #1;
    check("we_before_reset", int'(fb_we), 1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_we", int'(fb_we), 0);
    check("reset_back_buf", int'(back_buf), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_fb_data", int'(fb_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full frame: opaque sprite, clipped sprite, disabled slot, half-transparent sprite.
    tab_en[0] = 1'b1; tab_x[0] = 10'd144; tab_y[0] = 9'd148; tab_spr[0] = 3'd0;
    tab_en[1] = 1'b1; tab_x[1] = 10'd300; tab_y[1] = 9'd170; tab_spr[1] = 3'd1;
    tab_en[2] = 1'b0; tab_x[2] = 10'd0;   tab_y[2] = 9'd0;   tab_spr[2] = 3'd2;
    tab_en[3] = 1'b1; tab_x[3] = 10'd144; tab_y[3] = 9'd20;  tab_spr[3] = 3'd3;
    push_bg(57600);
    push_sprite(144, 148, 0);
    push_sprite(300, 170, 1);
    push_sprite(144, 20, 3);
    nwr = 0;
    max_addr = 0;
    frame_event();
    check("swap_after_reset", int'(back_buf), 1);

    cnt = 0;
    bound_hit = 1;
    while (cnt < 70000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 1000 || cnt == 60676) begin
        pix_stb = 1'b1;
        screenend = 1'b1;
      end
      if (cnt == 1001 || cnt == 60677) begin
        pix_stb = 1'b0;
        screenend = 1'b0;
        check("overrun_pulse", int'(overrun), 1);
        check("no_swap_busy", int'(back_buf), 1);
      end
      if (cnt == 1002) begin
        check("overrun_one_clk", int'(overrun), 0);
        check("bg_continues", int'(busy), 1);
      end
      if (cnt == 2000) screenend = 1'b1;
      if (cnt == 2001) begin
        screenend = 1'b0;
        check("unqualified_event", int'(overrun), 0);
      end
      if (!busy) begin
        bound_hit = 0;
        break;
      end
    end
    pix_stb = 1'b0;
    screenend = 1'b0;
    check("done_timeout", bound_hit, 0);
    check("busy_cycles", cnt, 57600 + 3 * 1025 + 1 + 1);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("write_count", nwr, 57600 + 1024 + 200 + 512);
    check("max_addr", max_addr, 57599);
    check("done_idle_overrun", int'(overrun), 0);

    // A frame event in DONE swaps normally and restarts the fill at address 0.
    push_bg(3);
    frame_event();
    check("swap_from_done", int'(back_buf), 0);
    check("busy_again", int'(busy), 1);
    wait_drained("restart_timeout", 100);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
